pipeline_rx: RTL

Result-side receiver for the 10-bit arithmetic pipeline `pipeline_ex`. The upstream side launches operands A/B/C/D into `pipeline_ex`. This block pairs the F output with a delayed launch-valid, so each result is captured exactly when it emerges. Captured results go into a small FIFO and are offered downstream over a valid/ready handshake. Dropped results are reported through a sticky overflow flag.

---
 rtl/pipeline_rx_pkg.sv | 11 +
 rtl/pipeline_rx_if.sv | 11 +
 rtl/pipeline_rx_sync_fifo.sv | 55 +++++
 rtl/pipeline_rx.sv | 67 ++++++
 4 files changed

// File: rtl/pipeline_rx_pkg.sv
// Shared constants for the pipeline_ex result receiver: data width, pipeline latency and FIFO depth.
package pipeline_rx_pkg;
  localparam int PIPE_N          = 10;
  localparam int PIPE_LAT        = 3;
  localparam int PIPE_FIFO_DEPTH = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pipeline_rx_if.sv
// Valid/ready result stream; the receiver drives it as master, the consumer as slave.
interface pipeline_rx_if #(
  parameter int N = 10
);
  logic         valid;
  logic         ready;
  logic [N-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_rx_sync_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only when a pop frees the slot.
module sync_fifo #(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [N-1:0]             din,
  input  logic                     pop,
  output logic [N-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_reg;
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/pipeline_rx.sv
// Captures pipeline_ex results LAT edges after each launch, buffers them and offers them downstream.
module pipeline_rx
  import pipeline_rx_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int LAT   = PIPE_LAT,
  parameter int DEPTH = PIPE_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N-1:0]           f_in,
  pipeline_rx_if.master          out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy
);
  logic [LAT-1:0] vd_reg;
  logic           overflow_reg;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  // Launch valid delayed to line up with the matching F value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_reg <= '0;
    end else begin
      vd_reg[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        vd_reg[i] <= vd_reg[i-1];
      end
    end
  end

  assign push = vd_reg[LAT-1];
  assign pop  = out.valid & out.ready;

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (f_in),
    .pop   (pop),
    .dout  (out.data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A result is lost only when the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (push && full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign out.valid = ~empty;
  assign overflow  = overflow_reg;
  assign busy      = (|vd_reg) | ~empty;
endmodule
